music_sequencer: RTL and testbench
==================================

# music_sequencer

Multi-channel, tempo-scaled song player for the board's PMOD audio amplifier. It is the parametrised successor of the single-voice level-driven player. It generates a beat tick whose rate tracks the game level, and it walks a beat address through an external note ROM. Each beat, it loads one half-period per channel and synthesises square-wave voices, XOR-mixing them onto the PMOD audio pin. It adds play/pause/restart control, one-shot or looping songs, per-channel mute and an inter-note articulation gap.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- NUM_CH, 2, number of voices (1..4).
- HP_W, 20, width of one channel half-period field, in clocks.
- ADDR_W, 9, beat address width.
- SONG_LEN, 512, number of beats in the song (2..2^ADDR_W).
- LOOP, 1, 1 = wrap to beat 0 at end; 0 = stop at end.
- GAP_CLKS, 0, number of clocks of forced silence at the start of every beat (0 disables).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- level  in  4  game level; 1..7 are valid, any other value is treated as 1.
- play  in  1  single-cycle pulse to start or resume playback.
- pause  in  1  single-cycle pulse to freeze playback.
- restart  in  1  single-cycle pulse to jump to beat 0 and play.
- ch_en  in  NUM_CH  per-channel enable; 0 mutes that channel.
- half_period  in  NUM_CH*HP_W  ROM data for beat_addr, channel c at bits [c*HP_W +: HP_W]; value 0 means rest.
- beat_addr  out  ADDR_W  current beat index into the note ROM (registered).
- beat_tick  out  1  single-cycle pulse when the beat advances.
- playing  out  1  high in the PLAY state.
- song_done  out  1  single-cycle pulse at the end of a non-looping song.
- pmod_1  out  1  audio output.
- pmod_2  out  1  gain select, tied to 1.
- pmod_4  out  1  amplifier enable.

## Operation
- States: IDLE, PLAY, PAUSE. Reset enters IDLE.
- Control priority is restart > pause > play, evaluated each cycle.
  - restart (any state): beat_addr←0, tick counter←0, go to PLAY, schedule a channel load.
  - pause: PLAY→PAUSE. In IDLE or PAUSE it is ignored.
  - play: IDLE→PLAY from beat 0 with a channel load; PAUSE→PLAY resumes the frozen counters. In PLAY it is ignored.
- Tempo:
  - lvl_q is latched from level at reset (as 1) and at every beat_tick.
  - DIV = CLK_HZ/(4+2*lvl_q), using integer constants computed at elaboration. Level 1 gives 6 beats/s; level 7 gives 18 beats/s.
  - The tick counter counts 0..DIV-1 in PLAY. At DIV-1 it pulses beat_tick, clears to 0 and advances beat_addr.
- End of song: a tick at beat_addr==SONG_LEN-1 behaves as follows.
  - LOOP=1: beat_addr←0 and playback continues.
  - LOOP=0: beat_addr←0, go to IDLE, pulse song_done. No beat_tick is issued.
- Channel load:
  - The load happens one cycle after beat_addr changes (tick, restart, or play from IDLE).
  - Each channel register hp_c←half_period field, its phase counter←0, and its square output←0.
- Voice: if hp_c≠0, the phase counter counts 0..hp_c-1 in PLAY and toggles the square output at wrap. If hp_c==0, the voice outputs 0.
- Mix: pmod_1 = XOR over c of (sq_c & ch_en[c]). The mix is forced to 0 when not in PLAY, and forced to 0 while the tick counter < GAP_CLKS.
- pmod_4 = 1 in PLAY or PAUSE, 0 in IDLE. pmod_2 = 1 always.

## Timing
- Reset values: beat_addr=0, beat_tick=0, playing=0, song_done=0, pmod_1=0, pmod_4=0, pmod_2=1, all hp_c=0.
- Beat period is exactly DIV clocks of PLAY time. Time spent in PAUSE does not count.
- beat_tick and the beat_addr change occur in the same cycle. hp_c updates at the next edge, so the ROM is read combinationally with 1 cycle of slack.
- A level change takes effect at the next beat boundary and never mid-beat.
- Tone frequency is CLK_HZ/(2*hp_c). A new note always starts at phase 0.
- Pause freezes the tick, beat and phase counters. On resume, counting continues from the frozen values with no extra cycle.
- restart during the final beat takes priority over the end-of-song action: no song_done is issued.
- play and pause in the same cycle: pause wins.
- Asserting reset mid-note returns all state to the reset values immediately, without waiting for a clock edge.

## Test plan
- Tempo (CLK_HZ=120, level=1, play pulse): beat_tick every 20 clocks. Switch level to 7 mid-beat: the current beat still lasts 20 clocks, and later beats last 6 clocks.
- Tone (NUM_CH=1, ROM returns 5): pmod_1 toggles every 5 clocks starting 0. ch_en=0 holds pmod_1 at 0. ROM value 0 gives constant 0.
- Mix (NUM_CH=2, hp=4 and 4, both enabled): pmod_1 stays 0. Mute ch1: pmod_1 toggles every 4 clocks.
- Pause/resume: pause at tick count 7. beat_addr, pmod_1 (=0) and counters are frozen, and pmod_4 stays 1. play resumes and the next tick arrives 13 PLAY clocks later.
- End (SONG_LEN=4, LOOP=0): after 4 beats, a song_done pulse, then IDLE, beat_addr=0 and pmod_4=0. With LOOP=1 the sequence is 0,1,2,3,0 with no song_done. restart at beat 3 gives beat_addr=0 and no song_done.
- GAP_CLKS=3 with a continuous tone: pmod_1=0 for the first 3 clocks of each beat. Asynchronous reset mid-beat sets all outputs to their reset values immediately.

Source files
------------

// File: rtl/music_sequencer.sv
// music_sequencer: multi-channel, tempo-scaled song player for the PMOD audio amplifier.
// A beat tick whose rate follows the game level walks beat_addr through an external note
// ROM. On each beat, one half-period per channel is loaded, and square-wave voices are
// XOR-mixed onto pmod_1.
// Ports:
//   clk, reset (async, active-low)
//   level       : game level, 1..7 valid, anything else plays as 1
//   play/pause/restart : single-cycle control pulses, priority restart > pause > play
//   ch_en       : per-channel enable (0 = muted)
//   half_period : ROM data for beat_addr, channel c at [c*HP_W +: HP_W], 0 = rest
//   beat_addr   : current beat index (registered)
//   beat_tick   : pulse when the beat advances
//   playing     : high in PLAY
//   song_done   : pulse at the end of a non-looping song
//   pmod_1      : audio, pmod_2 : gain select (1), pmod_4 : amplifier enable
module music_sequencer #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned HP_W     = 20,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned SONG_LEN = 512,
  parameter bit          LOOP     = 1'b1,
  parameter int unsigned GAP_CLKS = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               level,
  input  logic                     play,
  input  logic                     pause,
  input  logic                     restart,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*HP_W-1:0]   half_period,
  output logic [ADDR_W-1:0]        beat_addr,
  output logic                     beat_tick,
  output logic                     playing,
  output logic                     song_done,
  output logic                     pmod_1,
  output logic                     pmod_2,
  output logic                     pmod_4
);

  localparam int unsigned TICK_W = $clog2(CLK_HZ / 6 + 1);

  // Terminal tick count (DIV-1) per level, DIV = CLK_HZ/(4+2*level)
  localparam logic [TICK_W-1:0] DM1_L1 = TICK_W'(CLK_HZ / 6  - 1);
  localparam logic [TICK_W-1:0] DM1_L2 = TICK_W'(CLK_HZ / 8  - 1);
  localparam logic [TICK_W-1:0] DM1_L3 = TICK_W'(CLK_HZ / 10 - 1);
  localparam logic [TICK_W-1:0] DM1_L4 = TICK_W'(CLK_HZ / 12 - 1);
  localparam logic [TICK_W-1:0] DM1_L5 = TICK_W'(CLK_HZ / 14 - 1);
  localparam logic [TICK_W-1:0] DM1_L6 = TICK_W'(CLK_HZ / 16 - 1);
  localparam logic [TICK_W-1:0] DM1_L7 = TICK_W'(CLK_HZ / 18 - 1);

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  state_t              state;
  logic [2:0]          lvl_q;
  logic [2:0]          lvl_next;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TICK_W-1:0]   div_m1;
  logic                load_q;
  logic [HP_W-1:0]     hp_q    [NUM_CH];
  logic [HP_W-1:0]     phase_q [NUM_CH];
  logic [NUM_CH-1:0]   sq_q;
  logic                run;
  logic                gap;
  logic                mix;

  assign lvl_next = (!level[3] && level[2:0] != 3'd0) ? level[2:0] : 3'd1;

  always_comb begin
    case (lvl_q)
      3'd2:    div_m1 = DM1_L2;
      3'd3:    div_m1 = DM1_L3;
      3'd4:    div_m1 = DM1_L4;
      3'd5:    div_m1 = DM1_L5;
      3'd6:    div_m1 = DM1_L6;
      3'd7:    div_m1 = DM1_L7;
      default: div_m1 = DM1_L1;
    endcase
  end

  // Counters advance only in PLAY cycles that carry no restart/pause request
  assign run = (state == PLAY) && !restart && !pause;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lvl_q     <= 3'd1;
      tick_cnt  <= '0;
      beat_addr <= '0;
      load_q    <= 1'b0;
      beat_tick <= 1'b0;
      song_done <= 1'b0;
    end else begin
      beat_tick <= 1'b0;
      song_done <= 1'b0;
      load_q    <= 1'b0;
      if (restart) begin
        beat_addr <= '0;
        tick_cnt  <= '0;
        state     <= PLAY;
        load_q    <= 1'b1;
      end else if (pause) begin
        if (state == PLAY) state <= PAUSE;
      end else if (play && state == IDLE) begin
        state     <= PLAY;
        beat_addr <= '0;
        tick_cnt  <= '0;
        load_q    <= 1'b1;
      end else if (play && state == PAUSE) begin
        state <= PLAY;
      end else if (state == PLAY) begin
        if (tick_cnt == div_m1) begin
          tick_cnt <= '0;
          load_q   <= 1'b1;
          if (beat_addr == LAST_BEAT) begin
            beat_addr <= '0;
            if (LOOP) begin
              beat_tick <= 1'b1;
              lvl_q     <= lvl_next;
            end else begin
              state     <= IDLE;
              song_done <= 1'b1;
            end
          end else begin
            beat_addr <= beat_addr + 1'b1;
            beat_tick <= 1'b1;
            lvl_q     <= lvl_next;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

  // Voices: the load reads the ROM one cycle after beat_addr moved and restarts at phase 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        hp_q[c]    <= '0;
        phase_q[c] <= '0;
      end
      sq_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (load_q) begin
          hp_q[c]    <= half_period[c*HP_W +: HP_W];
          phase_q[c] <= '0;
          sq_q[c]    <= 1'b0;
        end else if (run && hp_q[c] != '0) begin
          if (phase_q[c] == hp_q[c] - 1'b1) begin
            phase_q[c] <= '0;
            sq_q[c]    <= ~sq_q[c];
          end else begin
            phase_q[c] <= phase_q[c] + 1'b1;
          end
        end
      end
    end
  end

  generate
    if (GAP_CLKS == 0) begin : gen_no_gap
      assign gap = 1'b0;
    end else begin : gen_gap
      assign gap = (32'(tick_cnt) < GAP_CLKS);
    end
  endgenerate

  always_comb begin
    mix = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      mix = mix ^ (sq_q[c] & ch_en[c]);
    end
  end

  assign playing = (state == PLAY);
  assign pmod_4  = (state != IDLE);
  assign pmod_2  = 1'b1;
  assign pmod_1  = mix & playing & ~gap;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: two instances (looping with an articulation gap, and one-shot
// without a gap) share the control stimulus. Each is compared every cycle against a
// behavioural model that derives square-wave levels from elapsed note time. A few
// hand-computed expectations pin tempo, pause, end of song, mixing and async reset.
module tb_music_sequencer;

  localparam int S_IDLE  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_PAUSE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] level = 4'd1;
  logic       play = 1'b0, pause = 1'b0, restart = 1'b0;
  logic [1:0] ch_en = 2'b11;
  logic [7:0] hp_a, hp_b;
  logic [2:0] addr_a, addr_b;
  logic       tick_a, tick_b, playing_a, playing_b, done_a, done_b;
  logic       p1_a, p1_b, p2_a, p2_b, p4_a, p4_b;

  logic [3:0] rom [2][8][2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state per instance
  int m_st   [2];
  int m_beat [2];
  int m_tick [2];
  int m_lvl  [2];
  int m_note [2];
  int m_hp   [2][2];
  bit m_load [2];
  bit m_bt   [2];
  bit m_sd   [2];

  always #5 clk = ~clk;

  assign hp_a = {rom[0][addr_a][1], rom[0][addr_a][0]};
  assign hp_b = {rom[1][addr_b][1], rom[1][addr_b][0]};

  music_sequencer #(
    .CLK_HZ(120), .NUM_CH(2), .HP_W(4), .ADDR_W(3),
    .SONG_LEN(6), .LOOP(1'b1), .GAP_CLKS(3)
  ) dut_a (
    .clk(clk), .reset(reset), .level(level), .play(play), .pause(pause),
    .restart(restart), .ch_en(ch_en), .half_period(hp_a), .beat_addr(addr_a),
    .beat_tick(tick_a), .playing(playing_a), .song_done(done_a),
    .pmod_1(p1_a), .pmod_2(p2_a), .pmod_4(p4_a)
  );

  music_sequencer #(
    .CLK_HZ(120), .NUM_CH(2), .HP_W(4), .ADDR_W(3),
    .SONG_LEN(4), .LOOP(1'b0), .GAP_CLKS(0)
  ) dut_b (
    .clk(clk), .reset(reset), .level(level), .play(play), .pause(pause),
    .restart(restart), .ch_en(ch_en), .half_period(hp_b), .beat_addr(addr_b),
    .beat_tick(tick_b), .playing(playing_b), .song_done(done_b),
    .pmod_1(p1_b), .pmod_2(p2_b), .pmod_4(p4_b)
  );

  function automatic int p_len(input int i);
    return (i == 0) ? 6 : 4;
  endfunction
  function automatic bit p_loop(input int i);
    return (i == 0);
  endfunction
  function automatic int p_gap(input int i);
    return (i == 0) ? 3 : 0;
  endfunction
  function automatic int beat_len(input int lvl);
    return 120 / (4 + 2 * lvl);
  endfunction
  function automatic int sane_level(input int lv);
    return (lv >= 1 && lv <= 7) ? lv : 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_st[i] = S_IDLE; m_beat[i] = 0; m_tick[i] = 0; m_lvl[i] = 1; m_note[i] = 0;
    m_load[i] = 0; m_bt[i] = 0; m_sd[i] = 0;
    m_hp[i][0] = 0; m_hp[i][1] = 0;
  endtask

  // One clock of the player, from the rules: beats last beat_len(level) PLAY cycles,
  // a note's square level is (time since note start / half-period) mod 2.
  task automatic model_step(input int i);
    bit run, ld;
    m_bt[i] = 0;
    m_sd[i] = 0;
    run = (m_st[i] == S_PLAY) && !restart && !pause;
    ld = m_load[i];
    m_load[i] = 0;
    if (ld) begin
      for (int c = 0; c < 2; c++) m_hp[i][c] = int'(rom[i][m_beat[i]][c]);
      m_note[i] = 0;
    end else if (run) begin
      m_note[i]++;
    end
    if (restart) begin
      m_beat[i] = 0; m_tick[i] = 0; m_st[i] = S_PLAY; m_load[i] = 1;
    end else if (pause) begin
      if (m_st[i] == S_PLAY) m_st[i] = S_PAUSE;
    end else if (play && m_st[i] == S_IDLE) begin
      m_beat[i] = 0; m_tick[i] = 0; m_st[i] = S_PLAY; m_load[i] = 1;
    end else if (play && m_st[i] == S_PAUSE) begin
      m_st[i] = S_PLAY;
    end else if (m_st[i] == S_PLAY) begin
      m_tick[i]++;
      if (m_tick[i] == beat_len(m_lvl[i])) begin
        m_tick[i] = 0;
        m_load[i] = 1;
        if (m_beat[i] + 1 == p_len(i)) begin
          m_beat[i] = 0;
          if (p_loop(i)) begin
            m_bt[i] = 1; m_lvl[i] = sane_level(int'(level));
          end else begin
            m_st[i] = S_IDLE; m_sd[i] = 1;
          end
        end else begin
          m_beat[i]++;
          m_bt[i] = 1; m_lvl[i] = sane_level(int'(level));
        end
      end
    end
  endtask

  function automatic int exp_audio(input int i);
    int x;
    x = 0;
    if (m_st[i] != S_PLAY || m_tick[i] < p_gap(i)) return 0;
    for (int c = 0; c < 2; c++)
      if (m_hp[i][c] != 0 && ch_en[c]) x = x ^ ((m_note[i] / m_hp[i][c]) % 2);
    return x;
  endfunction

  task automatic cmp_inst(input int i, input int addr, input int tk, input int pl,
                          input int dn, input int p1, input int p2, input int p4);
    string n;
    n = (i == 0) ? "a" : "b";
    chk({n, ".beat_addr"}, addr, m_beat[i]);
    chk({n, ".beat_tick"}, tk, int'(m_bt[i]));
    chk({n, ".playing"}, pl, int'(m_st[i] == S_PLAY));
    chk({n, ".song_done"}, dn, int'(m_sd[i]));
    chk({n, ".pmod_1"}, p1, exp_audio(i));
    chk({n, ".pmod_2"}, p2, 1);
    chk({n, ".pmod_4"}, p4, int'(m_st[i] != S_IDLE));
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!reset) model_reset(i);
        else model_step(i);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        cmp_inst(0, int'(addr_a), int'(tick_a), int'(playing_a), int'(done_a),
                 int'(p1_a), int'(p2_a), int'(p4_a));
        cmp_inst(1, int'(addr_b), int'(tick_b), int'(playing_b), int'(done_b),
                 int'(p1_b), int'(p2_b), int'(p4_b));
      end
    end
  end

  // Called at a falling edge; the pulse is sampled by the next rising edge.
  task automatic pulse(input int which);
    if (which == 0) play = 1'b1;
    else if (which == 1) pause = 1'b1;
    else restart = 1'b1;
    @(negedge clk);
    play = 1'b0; pause = 1'b0; restart = 1'b0;
  endtask

  task automatic wait_tick_a(output int n);
    n = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (tick_a) begin
        n = k;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic fill_rom_random();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 8; a++)
        for (int c = 0; c < 2; c++)
          rom[i][a][c] = 4'($urandom_range(0, 6));
  endtask

  initial begin
    int n, n2, nt;
    bit seen;
    fill_rom_random();
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst beat_addr", int'(addr_a), 0);
    chk("rst playing", int'(playing_a), 0);
    chk("rst pmod_1", int'(p1_a), 0);
    chk("rst pmod_2", int'(p2_a), 1);
    chk("rst pmod_4", int'(p4_a), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Tempo: level 1 -> 20-clock beats, level 7 latched at a boundary -> 6-clock beats
    level = 4'd1;
    pulse(0);
    wait_tick_a(n);
    chk("tempo first beat", n, 20);
    repeat (10) @(negedge clk);
    level = 4'd7;
    wait_tick_a(n2);
    chk("tempo beat with mid-beat level change", 10 + n2, 20);
    wait_tick_a(n);
    chk("tempo beat at level 7", n, 6);
    level = 4'd1;
    wait_tick_a(n);
    chk("tempo last level-7 beat", n, 6);

    // Pause at tick count 7, resume: 13 more PLAY clocks to the tick
    pulse(2);
    repeat (7) @(negedge clk);
    pulse(1);
    repeat (10) @(negedge clk);
    chk("pause beat_addr frozen", int'(addr_a), 0);
    chk("pause pmod_1", int'(p1_a), 0);
    chk("pause pmod_4", int'(p4_a), 1);
    chk("pause playing", int'(playing_a), 0);
    pulse(0);
    wait_tick_a(n);
    chk("resume to tick", n, 13);

    // One-shot end on instance b: three beat ticks, then song_done and IDLE
    pulse(2);
    nt = 0;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (tick_b) nt++;
      if (done_b) begin
        seen = 1'b1;
        break;
      end
    end
    chk("end song_done seen", int'(seen), 1);
    chk("end beat ticks", nt, 3);
    chk("end pmod_4", int'(p4_b), 0);
    chk("end beat_addr", int'(addr_b), 0);
    chk("end playing", int'(playing_b), 0);
    @(negedge clk);

    // restart during the final beat suppresses song_done
    pulse(2);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (addr_b == 3'd3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reached last beat", int'(seen), 1);
    @(negedge clk);
    pulse(2);
    chk("restart last beat song_done", int'(done_b), 0);
    chk("restart last beat addr", int'(addr_b), 0);
    chk("restart last beat playing", int'(playing_b), 1);

    // Mix: two equal tones cancel; muting one leaves a 4-clock square
    for (int a = 0; a < 8; a++) begin
      rom[1][a][0] = 4'd4;
      rom[1][a][1] = 4'd4;
    end
    ch_en = 2'b11;
    pulse(2);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      chk("mix equal tones", int'(p1_b), 0);
    end
    @(negedge clk);
    ch_en = 2'b01;
    pulse(2);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      chk("mix one voice", int'(p1_b), int'(k >= 5 && k <= 8));
    end
    @(negedge clk);

    // Randomized control traffic against the model
    fill_rom_random();
    for (int k = 0; k < 3000; k++) begin
      restart = ($urandom_range(0, 199) == 0);
      pause   = ($urandom_range(0, 59) == 0);
      play    = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) ch_en = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 1499) != 0);
      @(negedge clk);
    end
    play = 1'b0; pause = 1'b0; restart = 1'b0; reset = 1'b1;
    ch_en = 2'b11;
    @(negedge clk);

    // Asynchronous reset mid-beat
    pulse(2);
    repeat (25) @(negedge clk);
    chk("pre-reset playing", int'(playing_a), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async rst addr_a", int'(addr_a), 0);
    chk("async rst addr_b", int'(addr_b), 0);
    chk("async rst playing", int'(playing_a), 0);
    chk("async rst tick", int'(tick_a), 0);
    chk("async rst done", int'(done_b), 0);
    chk("async rst pmod_1", int'(p1_a), 0);
    chk("async rst pmod_4", int'(p4_a), 0);
    chk("async rst pmod_2", int'(p2_a), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
